mul_share_arb: RTL and testbench

- Two-requester scheduler that shares the single 8x8 Braun array multiplier (braunmul) and adds per-requester accumulation.
- Each requester issues {a, b, op} over a valid/ready channel; a round-robin arbiter grants one request per cycle.
- The granted request passes through a 2-stage pipeline: operand register -> multiplier -> accumulate/result register.
- Results return on one shared valid/ready result channel tagged with the requester id. The block sits between the host-facing ports and the multiplier datapath.

---
 rtl/mul_share_pkg.sv | 22 ++
 rtl/braunmul.sv | 57 +++++
 rtl/mul_share_arb.sv | 180 ++++++++++++++++++
 tb/tb_mul_share_arb.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// Shared definitions for the two-requester multiply/accumulate scheduler.
package mul_share_pkg;

  localparam int NREQ      = 2;
  localparam int ACC_W_DEF = 20;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MAC  = 2'b01,
    OP_LOAD = 2'b10
  } op_e;

  // Encoding 2'b11 is reserved and behaves as a plain multiply.
  function automatic op_e norm_op(input logic [1:0] raw);
    case (raw)
      2'b01:   return OP_MAC;
      2'b10:   return OP_LOAD;
      default: return OP_MUL;
    endcase
  endfunction

endpackage

// File: rtl/braunmul.sv
// 8x8 unsigned Braun array multiplier: a carry-save array of full adders
// with a ripple-carry adder closing the upper half of the product.
module braunmul (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  logic [7:0] sum_s [8];
  logic [7:0] car_s [8];
  logic       x_s;
  logic       y_s;
  logic       z_s;
  logic       rc_s;

  // Carry-save array rows followed by the final ripple row.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      sum_s[i] = 8'd0;
      car_s[i] = 8'd0;
    end
    p    = 16'd0;
    x_s  = 1'b0;
    y_s  = 1'b0;
    z_s  = 1'b0;
    rc_s = 1'b0;
    for (int j = 0; j < 8; j++) begin
      sum_s[0][j] = a[j] & b[0];
      car_s[0][j] = 1'b0;
    end
    for (int i = 1; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        x_s = a[j] & b[i];
        if (j < 7) begin
          y_s = sum_s[i-1][j+1];
        end else begin
          y_s = 1'b0;
        end
        z_s = car_s[i-1][j];
        sum_s[i][j] = x_s ^ y_s ^ z_s;
        car_s[i][j] = (x_s & y_s) | (x_s & z_s) | (y_s & z_s);
      end
    end
    for (int i = 0; i < 8; i++) begin
      p[i] = sum_s[i][0];
    end
    rc_s = 1'b0;
    for (int j = 0; j < 7; j++) begin
      y_s      = sum_s[7][j+1];
      z_s      = car_s[7][j];
      p[8+j]   = y_s ^ z_s ^ rc_s;
      rc_s     = (y_s & z_s) | (y_s & rc_s) | (z_s & rc_s);
    end
    p[15] = car_s[7][7] ^ rc_s;
  end

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin scheduler sharing one braunmul between two requesters, with
// per-requester accumulators and a single tagged result channel.
module mul_share_arb
  import mul_share_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  input  logic [3:0]       req_op,
  input  logic [1:0]       acc_clr,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [ACC_W-1:0] res_data,
  output logic             busy
);

  // Arbitration and stage 1 state
  logic             last_r;
  logic             s1_full_r;
  logic [7:0]       s1_a_r;
  logic [7:0]       s1_b_r;
  op_e              s1_op_r;
  logic             s1_id_r;

  // Output stage and accumulators
  logic             res_valid_r;
  logic             res_id_r;
  logic [ACC_W-1:0] res_data_r;
  logic [ACC_W-1:0] acc_r [NREQ];

  logic [1:0]       grant_s;
  logic             adv_out_s;
  logic             adv_s1_s;
  logic [1:0]       hs_s;
  logic             hs_id_s;
  logic [7:0]       sel_a_s;
  logic [7:0]       sel_b_s;
  op_e              sel_op_s;
  logic [15:0]      prod_s;
  logic [ACC_W-1:0] prod_ext_s;
  logic [ACC_W-1:0] acc_sel_s;
  logic [ACC_W-1:0] res_next_s;
  logic             acc_we_s;
  logic             s2_fire_s;

  assign adv_out_s = ~res_valid_r | res_ready;
  assign adv_s1_s  = ~s1_full_r | adv_out_s;
  // Ready is forced low while reset is held so nothing is accepted then.
  assign req_ready = grant_s & {2{adv_s1_s}} & {2{rst_n}};
  assign hs_s      = req_valid & req_ready;
  assign hs_id_s   = hs_s[1];
  assign s2_fire_s = adv_out_s & s1_full_r;

  // Round-robin grant: on contention the requester that did not win last.
  always_comb begin
    grant_s = 2'b00;
    case (req_valid)
      2'b01: grant_s = 2'b01;
      2'b10: grant_s = 2'b10;
      2'b11: begin
        if (last_r) begin
          grant_s = 2'b01;
        end else begin
          grant_s = 2'b10;
        end
      end
      default: grant_s = 2'b00;
    endcase
  end

  // Operand mux selecting the fields of the requester being accepted.
  always_comb begin
    sel_a_s  = 8'd0;
    sel_b_s  = 8'd0;
    sel_op_s = OP_MUL;
    if (hs_id_s) begin
      sel_a_s  = req_a[15:8];
      sel_b_s  = req_b[15:8];
      sel_op_s = norm_op(req_op[3:2]);
    end else begin
      sel_a_s  = req_a[7:0];
      sel_b_s  = req_b[7:0];
      sel_op_s = norm_op(req_op[1:0]);
    end
  end

  braunmul u_mul (
    .a (s1_a_r),
    .b (s1_b_r),
    .p (prod_s)
  );

  assign prod_ext_s = ACC_W'(prod_s);
  assign acc_sel_s  = acc_r[s1_id_r];

  // Stage-2 result and accumulator write selection by operation.
  always_comb begin
    res_next_s = prod_ext_s;
    acc_we_s   = 1'b0;
    case (s1_op_r)
      OP_MAC: begin
        res_next_s = acc_sel_s + prod_ext_s;
        acc_we_s   = 1'b1;
      end
      OP_LOAD: begin
        res_next_s = prod_ext_s;
        acc_we_s   = 1'b1;
      end
      default: begin
        res_next_s = prod_ext_s;
        acc_we_s   = 1'b0;
      end
    endcase
  end

  // Stage 1: capture the granted request and update the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r    <= 1'b1;
      s1_full_r <= 1'b0;
      s1_a_r    <= 8'd0;
      s1_b_r    <= 8'd0;
      s1_op_r   <= OP_MUL;
      s1_id_r   <= 1'b0;
    end else if (adv_s1_s) begin
      s1_full_r <= |hs_s;
      if (|hs_s) begin
        s1_a_r  <= sel_a_s;
        s1_b_r  <= sel_b_s;
        s1_op_r <= sel_op_s;
        s1_id_r <= hs_id_s;
        last_r  <= hs_id_s;
      end
    end
  end

  // Output stage: holds its contents while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_id_r    <= 1'b0;
      res_data_r  <= '0;
    end else if (adv_out_s) begin
      res_valid_r <= s1_full_r;
      if (s1_full_r) begin
        res_id_r   <= s1_id_r;
        res_data_r <= res_next_s;
      end
    end
  end

  // Accumulators: a clear takes priority over a same-edge MAC/LOAD write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        acc_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (acc_clr[k]) begin
          acc_r[k] <= '0;
        end else if (s2_fire_s && acc_we_s && (int'(s1_id_r) == k)) begin
          acc_r[k] <= res_next_s;
        end
      end
    end
  end

  assign res_valid = res_valid_r;
  assign res_id    = res_id_r;
  assign res_data  = res_data_r;
  assign busy      = s1_full_r | res_valid_r;

endmodule

// File: tb/tb_mul_share_arb.sv
// Scoreboard bench for mul_share_arb: expected results are pushed when a
// request handshake is seen and popped when the result handshake occurs.
module tb_mul_share_arb;

  localparam int ACC_W = 20;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [15:0]      req_a;
  logic [15:0]      req_b;
  logic [3:0]       req_op;
  logic [1:0]       acc_clr;
  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic [ACC_W-1:0] res_data;
  logic             busy;

  mul_share_arb #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .acc_clr   (acc_clr),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
  } op_t;

  typedef struct {
    logic             id;
    logic [ACC_W-1:0] data;
  } res_t;

  op_t              pend0[$];
  op_t              pend1[$];
  res_t             sb[$];
  res_t             res_log[$];
  int               grant_log[$];
  int               res_cyc[$];
  logic [ACC_W-1:0] acc_m[2];
  logic [1:0]       hs_q;
  int               cyc;
  int               checks;
  int               errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  function automatic op_t mk(input int a, input int b, input logic [1:0] op);
    op_t o;
    o.a  = 8'(a);
    o.b  = 8'(b);
    o.op = op;
    return o;
  endfunction

  // Sample at the falling edge: model updates, scoreboard push/pop.
  task automatic sample_neg();
    res_t        e;
    logic [15:0] p;
    logic [1:0]  op;
    @(negedge clk);
    cyc++;
    hs_q = req_valid & req_ready;
    checks++;
    if (req_ready == 2'b11) begin
      errors++;
      $display("FAIL one_hot_ready got=%b required=at most one bit", req_ready);
    end
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (acc_clr[k]) acc_m[k] = '0;
      end
      for (int k = 0; k < 2; k++) begin
        if (hs_q[k]) begin
          p  = 16'(req_a[8*k +: 8]) * 16'(req_b[8*k +: 8]);
          op = req_op[2*k +: 2];
          e.id = 1'(k);
          if (op == 2'b01) begin
            acc_m[k] = acc_m[k] + ACC_W'(p);
            e.data   = acc_m[k];
          end else if (op == 2'b10) begin
            acc_m[k] = ACC_W'(p);
            e.data   = ACC_W'(p);
          end else begin
            e.data = ACC_W'(p);
          end
          sb.push_back(e);
          grant_log.push_back(k);
        end
      end
      if (res_valid && res_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got id=%0d data=%0d required=no result", res_id, res_data);
        end else begin
          e = sb.pop_front();
          if (res_id !== e.id || res_data !== e.data) begin
            errors++;
            $display("FAIL sb_result got id=%0d data=%0d required id=%0d data=%0d",
                     res_id, res_data, e.id, e.data);
          end
        end
        e.id   = res_id;
        e.data = res_data;
        res_log.push_back(e);
        res_cyc.push_back(cyc);
      end
    end
  endtask

  // Drive after the rising edge: refill a requester once its handshake is done.
  task automatic drive_pos();
    op_t o;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (hs_q[k] || !req_valid[k]) begin
        if (k == 0 && pend0.size() != 0) begin
          o = pend0.pop_front();
          req_valid[0] = 1'b1;
          req_a[7:0] = o.a; req_b[7:0] = o.b; req_op[1:0] = o.op;
        end else if (k == 1 && pend1.size() != 0) begin
          o = pend1.pop_front();
          req_valid[1] = 1'b1;
          req_a[15:8] = o.a; req_b[15:8] = o.b; req_op[3:2] = o.op;
        end else begin
          req_valid[k] = 1'b0;
        end
      end
    end
    hs_q = 2'b00;
  endtask

  task automatic cycle();
    sample_neg();
    drive_pos();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || pend0.size() != 0 || pend1.size() != 0 ||
            req_valid != 2'b00) && n < 100) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL %s_drain got pending=%0d required=0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    logic bad;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00 || res_valid !== 1'b0 || res_id !== 1'b0 ||
        res_data !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b id=%b data=%0d busy=%b required 00/0/0/0/0",
               req_ready, res_valid, res_id, res_data, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = 2'b00;
    pend0.push_back(mk(7, 9, 2'b00));
    cycle();
    sample_neg();
    drive_pos();
    rst_n = 1'b0;
    sb.delete();
    acc_m[0] = '0; acc_m[1] = '0;
    req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got vld=%b rdy=%b busy=%b required 0/00/0",
               res_valid, req_ready, busy);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (res_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_discard got res_valid=1 required=0");
    end
    res_log.delete();
    pend0.push_back(mk(3, 4, 2'b01));
    drain("reset_mac");
    checks++;
    if (res_log.size() != 1 || res_log[0].data !== 20'd12 || res_log[0].id !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_mac got n=%0d required one result id 0 data 12", res_log.size());
    end
  endtask

  task automatic test_latency();
    req_valid = 2'b01;
    req_a[7:0] = 8'd255; req_b[7:0] = 8'd255; req_op[1:0] = 2'b00;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL lat_ready got=%b required=01", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_early got res_valid=%b required=0", res_valid);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_id !== 1'b0 || res_data !== 20'h0FE01) begin
      errors++;
      $display("FAIL lat_result got vld=%b id=%b data=%0d required 1/0/65025",
               res_valid, res_id, res_data);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL lat_idle got vld=%b busy=%b required 0/0", res_valid, busy);
    end
    hs_q = 2'b00;
  endtask

  task automatic test_wrap();
    res_log.delete();
    pend1.push_back(mk(10, 10, 2'b01));
    pend1.push_back(mk(20, 20, 2'b01));
    pend1.push_back(mk(255, 255, 2'b01));
    pend1.push_back(mk(255, 255, 2'b10));
    for (int i = 0; i < 16; i++) pend1.push_back(mk(255, 255, 2'b01));
    drain("wrap");
    checks++;
    if (res_log.size() != 20) begin
      errors++;
      $display("FAIL wrap_count got=%0d required=20", res_log.size());
    end else begin
      checks++;
      if (res_log[0].data !== 20'd100 || res_log[1].data !== 20'd500 ||
          res_log[2].data !== 20'd65525 || res_log[3].data !== 20'd65025 ||
          res_log[19].data !== 20'd56849 || res_log[19].id !== 1'b1) begin
        errors++;
        $display("FAIL wrap_values got %0d %0d %0d %0d %0d required 100 500 65525 65025 56849",
                 res_log[0].data, res_log[1].data, res_log[2].data,
                 res_log[3].data, res_log[19].data);
      end
    end
  endtask

  task automatic test_alternate();
    grant_log.delete(); res_log.delete(); res_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      pend0.push_back(mk(i + 1, 2, 2'b00));
      pend1.push_back(mk(i + 10, 3, 2'b00));
    end
    drain("alt");
    checks++;
    if (grant_log.size() != 8 || res_log.size() != 8) begin
      errors++;
      $display("FAIL alt_count got grants=%0d results=%0d required 8/8",
               grant_log.size(), res_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (grant_log[i] != (i % 2) || int'(res_log[i].id) != (i % 2) ||
            res_cyc[i] != res_cyc[0] + i) begin
          errors++;
          $display("FAIL alt_order idx=%0d got grant=%0d id=%0d cyc=%0d required %0d/%0d/%0d",
                   i, grant_log[i], res_log[i].id, res_cyc[i], i % 2, i % 2, res_cyc[0] + i);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic             id0;
    logic [ACC_W-1:0] d0;
    grant_log.delete(); res_log.delete();
    for (int i = 0; i < 3; i++) begin
      pend0.push_back(mk(i + 3, 7, 2'b00));
      pend1.push_back(mk(i + 40, 5, 2'b11));
    end
    cycle(); cycle(); cycle();
    res_ready = 1'b0;
    id0 = 1'b0;
    d0  = '0;
    for (int i = 0; i < 3; i++) begin
      sample_neg();
      if (i == 0) begin
        id0 = res_id;
        d0  = res_data;
      end
      checks++;
      if (res_valid !== 1'b1 || req_ready !== 2'b00 || busy !== 1'b1 ||
          res_id !== id0 || res_data !== d0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got vld=%b rdy=%b busy=%b id=%b data=%0d required 1/00/1/%b/%0d",
                 i, res_valid, req_ready, busy, res_id, res_data, id0, d0);
      end
      drive_pos();
    end
    res_ready = 1'b1;
    drain("stall");
    checks++;
    if (grant_log.size() != 6 || res_log.size() != 6) begin
      errors++;
      $display("FAIL stall_count got grants=%0d results=%0d required 6/6",
               grant_log.size(), res_log.size());
    end
  endtask

  task automatic test_clear();
    pend0.push_back(mk(5, 10, 2'b10));
    drain("clr_load");
    res_log.delete();
    pend0.push_back(mk(2, 3, 2'b01));
    pend0.push_back(mk(1, 1, 2'b01));
    cycle();
    sample_neg();
    drive_pos();
    acc_clr = 2'b01;
    sample_neg();
    drive_pos();
    acc_clr = 2'b00;
    drain("clr");
    checks++;
    if (res_log.size() != 2 || res_log[0].data !== 20'd56 || res_log[1].data !== 20'd1) begin
      errors++;
      $display("FAIL clear_values got n=%0d required 56 then 1", res_log.size());
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_a = 16'd0; req_b = 16'd0; req_op = 4'd0;
    acc_clr = 2'b00;
    res_ready = 1'b1;
    hs_q = 2'b00;
    acc_m[0] = '0; acc_m[1] = '0;
    test_reset();
    test_latency();
    test_wrap();
    test_alternate();
    test_stall();
    test_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
